shift_counter: RTL and testbench

- Parametrised shift-register counter. It generalises the fixed 2-bit ring and Johnson counters to WIDTH bits.
- Mode (ring or Johnson) and direction are selectable at run time.
- Adds count enable, parallel load, a wrap pulse, and self-correction of illegal states.
- Used as a one-hot or thermometer phase sequencer for downstream muxing and timing logic.

---
 rtl/shift_counter_pkg.sv | 15 +
 rtl/shift_counter_legal_chk.sv | 28 ++
 rtl/shift_counter.sv | 74 +++++++
 tb/tb_shift_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the shift_counter phase sequencer.
// Mode/direction encodings and the per-mode home pattern.
package shift_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  // Ring starts one-hot at bit 0; Johnson starts all-clear.
  function automatic logic [31:0] home_pattern(input logic mode, input int unsigned width);
    return (mode == MODE_RING && width != 0) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/shift_counter_legal_chk.sv
// Combinational legality check of a counter state for the selected mode.
// Ring: exactly one bit set. Johnson: at most one non-circular adjacent-bit transition.
module shift_counter_legal_chk
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] dout,
  input  logic             mode,
  output logic             legal
);

  logic [5:0] ones;
  logic [5:0] trans;

  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {5'd0, dout[i]};
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans = trans + {5'd0, dout[i] ^ dout[i+1]};
    end
    legal = (mode == MODE_RING) ? (ones == 6'd1) : (trans <= 6'd1);
  end

endmodule

// File: rtl/shift_counter.sv
// Run-time selectable ring / Johnson shift counter with load, enable,
// wrap pulse and self-correction of illegal states.
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             err
);

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] home;
  logic             tc_q;
  logic             err_q;
  logic             legal;

  assign home = WIDTH'(home_pattern(mode, WIDTH));

  shift_counter_legal_chk #(.WIDTH(WIDTH)) u_legal_chk (
    .dout  (dout_q),
    .mode  (mode),
    .legal (legal)
  );

  // Johnson differs from ring only by inverting the bit fed back around.
  always_comb begin
    shift_d = dout_q;
    if (dir == DIR_UP) begin
      shift_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1] ^ (mode == MODE_JOHNSON)};
    end else begin
      shift_d = {dout_q[0] ^ (mode == MODE_JOHNSON), dout_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= home;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (load) begin
      dout_q <= load_val;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (en) begin
      if (!legal) begin
        dout_q <= home;
        tc_q   <= 1'b0;
        err_q  <= 1'b1;
      end else begin
        dout_q <= shift_d;
        tc_q   <= (shift_d == home);
        err_q  <= 1'b0;
      end
    end else begin
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end
  end

  assign dout = dout_q;
  assign tc   = tc_q;
  assign err  = err_q;

endmodule

// File: tb/tb_shift_counter.sv
// Directed bench for shift_counter (WIDTH=4) with hand-computed expectations.
module tb_shift_counter;

  logic       clk = 1'b0;
  logic       rst, en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] dout;
  logic       tc, err;

  logic [3:0] chk_dout;
  logic       chk_mode;
  logic       chk_legal;

  int checks = 0;
  int errors = 0;

  shift_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .dout     (dout),
    .tc       (tc),
    .err      (err)
  );

  shift_counter_legal_chk #(.WIDTH(4)) u_chk (
    .dout  (chk_dout),
    .mode  (chk_mode),
    .legal (chk_legal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] d, input logic t, input logic e);
    check({tag, ".dout"}, {28'd0, dout}, {28'd0, d});
    check({tag, ".tc"}, {31'd0, tc}, {31'd0, t});
    check({tag, ".err"}, {31'd0, err}, {31'd0, e});
  endtask

  logic [3:0] ring_up[4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] ring_dn[4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] john_up[8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                              4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] john_dn[8]  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                              4'b0111, 4'b0011, 4'b0001, 4'b0000};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
    chk_dout = 4'b0000; chk_mode = 1'b0;

    // Legality checker vectors
    #1;
    chk_dout = 4'b1000; chk_mode = 1'b0; #1; check("lc.ring1000", {31'd0, chk_legal}, 32'd1);
    chk_dout = 4'b0000; chk_mode = 1'b0; #1; check("lc.ring0000", {31'd0, chk_legal}, 32'd0);
    chk_dout = 4'b0110; chk_mode = 1'b0; #1; check("lc.ring0110", {31'd0, chk_legal}, 32'd0);
    chk_dout = 4'b1110; chk_mode = 1'b1; #1; check("lc.john1110", {31'd0, chk_legal}, 32'd1);
    chk_dout = 4'b0110; chk_mode = 1'b1; #1; check("lc.john0110", {31'd0, chk_legal}, 32'd0);
    chk_dout = 4'b1111; chk_mode = 1'b1; #1; check("lc.john1111", {31'd0, chk_legal}, 32'd1);

    // Reset in ring mode, then ring up
    step();
    expect_state("rst.ring", 4'b0001, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_state($sformatf("ring_up%0d", i), ring_up[i], i == 3, 1'b0);
    end
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_state($sformatf("ring_dn%0d", i), ring_dn[i], i == 3, 1'b0);
    end

    // Johnson up then down
    rst = 1'b1; mode = 1'b1; dir = 1'b0;
    step();
    expect_state("rst.john", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_state($sformatf("john_up%0d", i), john_up[i], i == 7, 1'b0);
    end
    dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_state($sformatf("john_dn%0d", i), john_dn[i], i == 7, 1'b0);
    end

    // Illegal load corrected in ring mode
    dir = 1'b0; mode = 1'b0; load = 1'b1; load_val = 4'b0110;
    step();
    expect_state("ld.ring", 4'b0110, 1'b0, 1'b0);
    load = 1'b0;
    step();
    expect_state("fix.ring", 4'b0001, 1'b0, 1'b1);
    step();
    expect_state("after.fix.ring", 4'b0010, 1'b0, 1'b0);

    // Illegal load corrected in Johnson mode
    mode = 1'b1; load = 1'b1; load_val = 4'b0101;
    step();
    expect_state("ld.john", 4'b0101, 1'b0, 1'b0);
    load = 1'b0;
    step();
    expect_state("fix.john", 4'b0000, 1'b0, 1'b1);
    step();
    expect_state("after.fix.john", 4'b0001, 1'b0, 1'b0);

    // Priority: rst over load over en
    rst = 1'b1; load = 1'b1; load_val = 4'b1011;
    step();
    expect_state("prio.rst", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0; load_val = 4'b0011;
    step();
    expect_state("prio.load", 4'b0011, 1'b0, 1'b0);
    load = 1'b0;
    step();
    expect_state("prio.shift", 4'b0111, 1'b0, 1'b0);

    // Ring to Johnson mid-run from a Johnson-legal one-hot state
    mode = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    expect_state("sw.ring0100", 4'b0100, 1'b0, 1'b0);
    step();
    expect_state("sw.ring1000", 4'b1000, 1'b0, 1'b0);
    mode = 1'b1;
    step();
    expect_state("sw.john0000", 4'b0000, 1'b1, 1'b0);
    step();
    expect_state("sw.john0001", 4'b0001, 1'b0, 1'b0);
    step();
    expect_state("sw.john0011", 4'b0011, 1'b0, 1'b0);

    // Illegal state held while disabled, corrected on enable
    mode = 1'b0; load = 1'b1; load_val = 4'b1010;
    step();
    expect_state("hold.ld", 4'b1010, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_state($sformatf("hold%0d", i), 4'b1010, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    expect_state("hold.fix", 4'b0001, 1'b0, 1'b1);
    en = 1'b0;
    step();
    expect_state("hold.idle", 4'b0001, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
